alu_cmd_sequencer: RTL

Command front-end for the 4-bit `ALU`. It buffers incoming operation commands in a small FIFO and drives registered, glitch-free operands into the combinational `ALU` one command at a time. It captures the 8-bit `Result` and presents it downstream over a valid/ready handshake. It sits directly upstream of `ALU`: it feeds the ALU and consumes what the ALU produces.

---
 rtl/alu_cmd_sequencer_pkg.sv | 32 +++
 rtl/alu_cmd_sequencer_if.sv | 42 ++++
 rtl/alu_cmd_fifo.sv | 47 ++++
 rtl/alu_cmd_sequencer.sv | 112 +++++++++++
 4 files changed

// File: rtl/alu_cmd_sequencer_pkg.sv
// Shared types for the ALU command sequencer: operation/mode enums, FSM states
// and the packed command word stored in the command FIFO.
package alu_cmd_sequencer_pkg;

  typedef enum logic [1:0] {
    ADD = 2'd0,
    SUB = 2'd1,
    MUL = 2'd2
  } sel_t;

  typedef enum logic {
    MODE_0 = 1'b0,
    MODE_1 = 1'b1
  } mode_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    HOLD  = 2'd2
  } seq_state_t;

  typedef struct packed {
    logic [3:0] Op1;
    logic [3:0] Op2;
    sel_t       Sel;
    logic       C_In;
    mode_t      Mode;
  } alu_cmd_t;

  localparam int ALU_SEQ_DEPTH = 4;

endpackage

// File: rtl/alu_cmd_sequencer_if.sv
// Bundle of the command, ALU-drive and result handshake signals around the sequencer.
// slave = sequencer side, master = surrounding logic (command source, ALU, result sink).
interface alu_cmd_sequencer_if;
  import alu_cmd_sequencer_pkg::*;

  logic       Cmd_Valid;
  logic       Cmd_Ready;
  logic [3:0] Cmd_Op1;
  logic [3:0] Cmd_Op2;
  sel_t       Cmd_Sel;
  logic       Cmd_C_In;
  mode_t      Cmd_Mode;

  logic [3:0] Alu_Op1;
  logic [3:0] Alu_Op2;
  sel_t       Alu_Sel;
  logic       Alu_C_In;
  mode_t      Alu_Mode;
  logic [7:0] Alu_Result;

  logic       Res_Valid;
  logic       Res_Ready;
  logic [7:0] Res_Data;
  logic       Res_Flag;

  modport slave (
    input  Cmd_Valid, Cmd_Op1, Cmd_Op2, Cmd_Sel, Cmd_C_In, Cmd_Mode,
    input  Alu_Result, Res_Ready,
    output Cmd_Ready,
    output Alu_Op1, Alu_Op2, Alu_Sel, Alu_C_In, Alu_Mode,
    output Res_Valid, Res_Data, Res_Flag
  );

  modport master (
    output Cmd_Valid, Cmd_Op1, Cmd_Op2, Cmd_Sel, Cmd_C_In, Cmd_Mode,
    output Alu_Result, Res_Ready,
    input  Cmd_Ready,
    input  Alu_Op1, Alu_Op2, Alu_Sel, Alu_C_In, Alu_Mode,
    input  Res_Valid, Res_Data, Res_Flag
  );

endinterface

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO with wrap-bit pointers; the head word is read combinationally.
module alu_cmd_fifo
  import alu_cmd_sequencer_pkg::*;
#(
  parameter int DEPTH = ALU_SEQ_DEPTH
) (
  input  logic     Clock,
  input  logic     nReset,
  input  logic     push,
  input  logic     pop,
  input  alu_cmd_t wdata,
  output alu_cmd_t rdata,
  output logic     full,
  output logic     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  alu_cmd_t    mem [DEPTH];

  logic do_push;
  logic do_pop;

  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage carries no reset; only the pointers decide what is valid.
  always_ff @(posedge Clock) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Command front-end for the 4-bit ALU: queues commands, drives registered ALU operands
// one at a time and returns each result over valid/ready. Macro ALU_SEQ_RANGE_FLAG_EN enables Res_Flag.
module alu_cmd_sequencer
  import alu_cmd_sequencer_pkg::*;
#(
  parameter int DEPTH = ALU_SEQ_DEPTH
) (
  input  logic                  Clock,
  input  logic                  nReset,
  alu_cmd_sequencer_if.slave    bus
);

  seq_state_t state;
  alu_cmd_t   cmd_in;
  alu_cmd_t   head;
  alu_cmd_t   alu_q;
  logic       full;
  logic       empty;
  logic       push;
  logic       pop;
  logic       res_valid_q;
  logic [7:0] res_data_q;

  assign cmd_in = '{Op1: bus.Cmd_Op1, Op2: bus.Cmd_Op2, Sel: bus.Cmd_Sel,
                    C_In: bus.Cmd_C_In, Mode: bus.Cmd_Mode};

  // Ready depends on occupancy only, so a same-edge pop never frees a slot for a push.
  assign push = bus.Cmd_Valid && !full;
  assign pop  = !empty && ((state == IDLE) || ((state == HOLD) && bus.Res_Ready));

  alu_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .Clock  (Clock),
    .nReset (nReset),
    .push   (push),
    .pop    (pop),
    .wdata  (cmd_in),
    .rdata  (head),
    .full   (full),
    .empty  (empty)
  );

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state       <= IDLE;
      alu_q       <= '{Op1: 4'd0, Op2: 4'd0, Sel: ADD, C_In: 1'b0, Mode: mode_t'(1'b0)};
      res_valid_q <= 1'b0;
      res_data_q  <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            alu_q <= head;
            state <= ISSUE;
          end
        end
        ISSUE: begin
          res_data_q  <= bus.Alu_Result;
          res_valid_q <= 1'b1;
          state       <= HOLD;
        end
        HOLD: begin
          if (bus.Res_Ready) begin
            res_valid_q <= 1'b0;
            if (pop) begin
              alu_q <= head;
              state <= ISSUE;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ALU_SEQ_RANGE_FLAG_EN
  logic res_flag_q;

  // Flags a result that escaped the 4-bit range: carry for ADD/MUL, borrow for SUB.
  function automatic logic range_flag(sel_t sel, logic [7:0] result);
    case (sel)
      ADD:     range_flag = (result > 8'd15);
      SUB:     range_flag = result[7];
      MUL:     range_flag = (result > 8'd15);
      default: range_flag = 1'b0;
    endcase
  endfunction

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      res_flag_q <= 1'b0;
    end else if (state == ISSUE) begin
      res_flag_q <= range_flag(alu_q.Sel, bus.Alu_Result);
    end
  end

  assign bus.Res_Flag = res_flag_q;
`else
  assign bus.Res_Flag = 1'b0;
`endif

  assign bus.Cmd_Ready = !full;
  assign bus.Alu_Op1   = alu_q.Op1;
  assign bus.Alu_Op2   = alu_q.Op2;
  assign bus.Alu_Sel   = alu_q.Sel;
  assign bus.Alu_C_In  = alu_q.C_In;
  assign bus.Alu_Mode  = alu_q.Mode;
  assign bus.Res_Valid = res_valid_q;
  assign bus.Res_Data  = res_data_q;

endmodule
